// File: rtl/secded_pkg.sv
// Shared types and codec helpers for the SECDED RAM.
// Holds the extended Hamming encoder used on every write path.
package secded_pkg;

  localparam int MAX_DW = 64;
  localparam int MAX_CW = 72;

  typedef enum logic [2:0] {
    INIT,
    WAIT,
    SREAD,
    SCHECK,
    SWRITE
  } state_t;

  typedef enum logic [1:0] {
    CLEAN,
    SBE,
    DBE
  } cls_t;

  function automatic int hp_bits(input int dw);
    int r;
    r = 0;
    for (int p = 30; p > 0; p--)
      if ((1 << p) >= dw + p + 1) r = p;
    return r;
  endfunction

  function automatic logic [MAX_CW-1:0] secded_encode(
    input logic [MAX_DW-1:0] d,
    input int                dw
  );
    logic [MAX_CW-1:0] c;
    int hp;
    int cw;
    int di;
    logic p;
    hp = hp_bits(dw);
    cw = dw + hp + 1;
    c  = '0;
    di = 0;
    for (int i = 0; i < MAX_CW - 1; i++)
      if (i < cw - 1 && ((i + 1) & i) != 0) begin
        c[i] = d[di];
        di++;
      end
    for (int k = 0; k < 7; k++)
      if (k < hp) begin
        p = 1'b0;
        for (int i = 0; i < MAX_CW - 1; i++)
          if (i < cw - 1 && (((i + 1) >> k) & 1) != 0)
            p = p ^ c[i];
        c[(1 << k) - 1] = p;
      end
    c[cw-1] = ^c;
    return c;
  endfunction

endpackage

// File: rtl/secded_decoder.sv
// Combinational SECDED decoder: syndrome, class, correction.
// Shared by host and scrub reads, which never overlap.
module secded_decoder
  import secded_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int HP     = hp_bits(DATA_W),
  localparam int CODE_W = DATA_W + HP + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic              sbe,
  output logic              dbe
);

  logic [HP-1:0]     syn;
  logic              ovr;
  int                sv;
  int                di;
  cls_t              cls;
  logic [CODE_W-2:0] fixed;

  // classify the word, flip the bad bit, strip parity
  always_comb begin
    syn = '0;
    for (int i = 0; i < CODE_W - 1; i++)
      for (int k = 0; k < HP; k++)
        if ((((i + 1) >> k) & 1) != 0)
          syn[k] = syn[k] ^ code[i];
    ovr = ^code;
    sv  = int'(syn);
    if (!ovr && sv == 0)
      cls = CLEAN;
    else if (ovr && sv <= CODE_W - 1)
      cls = SBE;
    else
      cls = DBE;
    fixed = code[CODE_W-2:0];
    for (int i = 0; i < CODE_W - 1; i++)
      if (cls == SBE && sv == i + 1)
        fixed[i] = ~code[i];
    data = '0;
    di   = 0;
    for (int i = 0; i < CODE_W - 1; i++)
      if (((i + 1) & i) != 0) begin
        data[di] = fixed[i];
        di++;
      end
    sbe = (cls == SBE);
    dbe = (cls == DBE);
  end

endmodule

// File: rtl/secded_ecc_ram.sv
// SECDED RAM with init sweep, scrubber and error stats.
// Host accesses always take priority over the scrubber.
module secded_ecc_ram
  import secded_pkg::*;
#(
  parameter  int DATA_W         = 32,
  parameter  int ADDR_W         = 8,
  parameter  int SCRUB_INTERVAL = 1024,
  parameter  int CNT_W          = 16,
  localparam int HP             = hp_bits(DATA_W),
  localparam int CODE_W         = DATA_W + HP + 1,
  localparam int DEPTH          = 2 ** ADDR_W,
  localparam int IW             = $clog2(SCRUB_INTERVAL)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CODE_W-1:0] wr_inj_mask,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_sbe,
  output logic              rd_dbe,
  input  logic              scrub_en,
  output logic              scrub_busy,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  ue_count,
  output logic [ADDR_W-1:0] err_addr
);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [CODE_W-1:0] rd_q;
  logic [CODE_W-1:0] wdata;
  logic [CODE_W-1:0] wb_code;
  logic [CODE_W-1:0] host_code;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] scrub_ptr;
  logic [ADDR_W-1:0] init_ptr;
  logic [ADDR_W-1:0] s1_addr;
  logic              we;
  logic              s1_host;
  logic              host_wr;
  logic              host_rd;
  logic              host_hit;
  logic              abort;
  logic [IW-1:0]     wait_cnt;
  state_t            state;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sbe;
  logic              dec_dbe;
  logic              host_ce;
  logic              host_ue;
  logic              scrub_ce;
  logic              scrub_ue;
  logic [CNT_W:0]    ce_sum;
  logic [CNT_W:0]    ue_sum;

  assign host_wr  = ready & wr_en;
  assign host_rd  = ready & rd_req;
  assign host_hit = host_wr && (wr_addr == scrub_ptr);
  assign raddr    = host_rd ? rd_addr : scrub_ptr;

  assign host_code =
    CODE_W'(secded_encode(MAX_DW'(wr_data), DATA_W))
    ^ wr_inj_mask;

  // single write port: init sweep, host, then scrub
  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = host_code;
    if (!rst) begin
      if (state == INIT) begin
        we    = 1'b1;
        waddr = init_ptr;
        wdata = CODE_W'(secded_encode('0, DATA_W));
      end else if (host_wr) begin
        we = 1'b1;
      end else if (state == SWRITE && !abort) begin
        we    = 1'b1;
        waddr = scrub_ptr;
        wdata = wb_code;
      end
    end
  end

  // array storage with registered read (old data on collision)
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  // tag the word in rd_q as host or scrub
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_host <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_host <= host_rd;
      s1_addr <= rd_addr;
    end
  end

  secded_decoder #(.DATA_W(DATA_W)) u_dec (
    .code (rd_q),
    .data (dec_data),
    .sbe  (dec_sbe),
    .dbe  (dec_dbe)
  );

  assign host_ce  = s1_host & dec_sbe;
  assign host_ue  = s1_host & dec_dbe;
  assign scrub_ce = (state == SCHECK) & dec_sbe;
  assign scrub_ue = (state == SCHECK) & dec_dbe;

  assign ce_sum = {1'b0, ce_count}
                + (CNT_W+1)'(host_ce)
                + (CNT_W+1)'(scrub_ce);
  assign ue_sum = {1'b0, ue_count}
                + (CNT_W+1)'(host_ue)
                + (CNT_W+1)'(scrub_ue);

  // host read results and saturating error statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_sbe   <= 1'b0;
      rd_dbe   <= 1'b0;
      ce_count <= '0;
      ue_count <= '0;
      err_addr <= '0;
    end else begin
      rd_valid <= s1_host;
      if (s1_host) begin
        rd_data <= dec_data;
        rd_sbe  <= dec_sbe;
        rd_dbe  <= dec_dbe;
      end
      ce_count <= ce_sum[CNT_W] ? '1 : ce_sum[CNT_W-1:0];
      ue_count <= ue_sum[CNT_W] ? '1 : ue_sum[CNT_W-1:0];
      if (host_ce | host_ue)
        err_addr <= s1_addr;
      else if (scrub_ce | scrub_ue)
        err_addr <= scrub_ptr;
    end
  end

  // init sweep and background scrubber
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_ptr   <= '0;
      ready      <= 1'b0;
      scrub_ptr  <= '0;
      wait_cnt   <= '0;
      scrub_busy <= 1'b0;
      abort      <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (&init_ptr) begin
            state <= WAIT;
            ready <= 1'b1;
          end
        end
        WAIT: begin
          if (scrub_en) begin
            if (wait_cnt == IW'(SCRUB_INTERVAL - 1)) begin
              wait_cnt   <= '0;
              state      <= SREAD;
              scrub_busy <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        SREAD: begin
          if (!rd_req) begin
            state <= SCHECK;
            abort <= host_hit;
          end
        end
        SCHECK: begin
          wb_code <= CODE_W'(secded_encode(
                       MAX_DW'(dec_data), DATA_W));
          abort   <= abort | host_hit;
          if (dec_sbe) begin
            state <= SWRITE;
          end else begin
            scrub_ptr  <= scrub_ptr + 1'b1;
            state      <= WAIT;
            scrub_busy <= 1'b0;
          end
        end
        SWRITE: begin
          if (abort || host_hit || !host_wr) begin
            scrub_ptr  <= scrub_ptr + 1'b1;
            state      <= WAIT;
            scrub_busy <= 1'b0;
            abort      <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/secded_ecc_ram.md
# secded_ecc_ram

Parametrised SECDED-protected RAM with a built-in codec, power-on initialisation sweep and background scrubber, for the TMR RISC-V memory subsystem. Writes are encoded to an extended Hamming codeword and reads are decoded, corrected and classified. An idle-time scrubber walks the array and writes corrected words back. Saturating counters and a last-error address register expose error statistics to the core.

## Interface
- DATA_W, 32: data bits per word (≥4).
- ADDR_W, 8: address bits; DEPTH = 2**ADDR_W.
- SCRUB_INTERVAL, 1024: idle cycles between scrub reads (≥2).
- CNT_W, 16: error counter width.
- Derived: HP = smallest p with 2**p ≥ DATA_W+p+1; CODE_W = DATA_W+HP+1 (32 → 39).
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the init sweep completes.
- wr_en  in  1  write strobe; ignored while !ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_inj_mask  in  CODE_W  XORed into the encoded word on host writes (fault injection); tie to 0 in normal use.
- rd_req  in  1  read strobe; ignored while !ready.
- rd_addr  in  ADDR_W  read address.
- rd_valid  out  1  read result valid (one-cycle pulse).
- rd_data  out  DATA_W  corrected data, or raw data on a DBE.
- rd_sbe / rd_dbe  out  1 each  single-bit corrected / uncorrectable, qualified by rd_valid.
- scrub_en  in  1  enables the scrubber.
- scrub_busy  out  1  high while the scrubber is outside WAIT.
- ce_count / ue_count  out  CNT_W each  saturating corrected / uncorrectable event counts.
- err_addr  out  ADDR_W  address of the most recent SBE or DBE (host or scrub).

## Operation
- Codeword layout, indices 0..CODE_W-1:
  - Parity bit k sits at index 2**k-1.
  - Overall parity sits at index CODE_W-1 and is the even parity of all other bits.
  - Data fills the remaining indices LSB-first.
  - Hamming parity k is the XOR of all positions j (1-based, j ≤ CODE_W-1) with bit k of j set.
- Decode: syndrome s (HP bits) and overall mismatch o.
  - s=0, o=0: clean.
  - o=1, s=0: overall-bit error; data is good; SBE.
  - o=1, 0<s≤CODE_W-1: flip position s, then SBE.
  - o=1, s>CODE_W-1: DBE.
  - o=0, s≠0: DBE; data is passed raw.
- FSM: INIT → WAIT → SREAD → SCHECK → SWRITE → WAIT.
  - INIT writes the encoding of 0 to addresses 0..DEPTH-1, one per cycle, then asserts ready.
  - WAIT counts idle cycles while scrub_en=1. On reaching SCRUB_INTERVAL-1 it moves to SREAD. scrub_en=0 holds the count.
  - SREAD issues a read of scrub_ptr when no host rd_req is present; otherwise it stalls.
  - SCHECK decodes the word.
    - Clean: scrub_ptr++ and go to WAIT.
    - DBE: count it, scrub_ptr++, go to WAIT; no write-back.
    - SBE: count it and go to SWRITE.
  - SWRITE writes back the corrected codeword when no host wr_en is present; otherwise it stalls.
    - If a host write to scrub_ptr occurs during SCHECK or SWRITE, the write-back is abandoned.
    - Either way scrub_ptr++ and the FSM returns to WAIT.
- scrub_ptr wraps from DEPTH-1 to 0.
- Host accesses always win over the scrubber. Host reads never write back.
- Counters saturate at all-ones. A host event and a scrub event in the same cycle add 2 (saturating).
- err_addr: on a simultaneous host and scrub event, the host address wins.

## Timing
- Reset values:
  - ready=0, rd_valid=0, rd_data=0, rd_sbe=0, rd_dbe=0, scrub_busy=0.
  - Counters=0, err_addr=0, scrub_ptr=0.
  - FSM enters INIT.
- RAM contents are not reset; INIT overwrites them.
- ready rises DEPTH cycles after rst deasserts.
- Reset asserted mid-operation aborts any pending write-back and restarts INIT.
- Read latency is 2:
  - rd_req at cycle n.
  - RAM output is registered at n+1.
  - Decoded outputs are registered with rd_valid=1 at n+2.
- Back-to-back reads are accepted every cycle.
- Read and write to the same address in the same cycle: the read returns the old contents.
- Counters and err_addr update in the same cycle as rd_valid (host) or in SCHECK (scrub).

## Structure
- Package secded_pkg holds:
  - function hp_bits(DATA_W);
  - function secded_encode;
  - syndrome-class constants CLEAN/SBE/DBE;
  - the FSM state enum.
- Sub-module secded_decoder: combinational, parametrised by DATA_W. Outputs corrected data, sbe and dbe. Instantiated once and shared by the host and scrub read paths, which are mutually exclusive per cycle.
- The RAM is an inferred array with one read port and one write port.

## Test plan
- Reset, wait 256 cycles → ready=1. Read addr 5 → rd_data=0, sbe=dbe=0, rd_valid exactly 2 cycles after rd_req.
- Write 0xDEADBEEF to addr 3 with wr_inj_mask=0x4 → read returns 0xDEADBEEF, rd_sbe=1, ce_count=1, err_addr=3.
- Write 0x12345678 to addr 9 with wr_inj_mask=0x6 → rd_dbe=1, rd_data is raw, ue_count=1, ce_count unchanged.
- SCRUB_INTERVAL=4; inject a single-bit error at addr 7; scrub_en=1 for one full pass →
  - ce_count incremented once by the scrubber;
  - a later host read of addr 7 returns clean data with sbe=0.
- Stall the scrubber in SWRITE with a continuous host wr_en to scrub_ptr using 0xA5A5A5A5 → write-back is abandoned and a read returns 0xA5A5A5A5 with no flags.
- CNT_W=4; produce 17 host SBEs → ce_count holds 15. Assert rst mid-sweep → ready drops and returns DEPTH cycles after release.
